julia_master_ctrl: RTL and testbench

Frame-level dispatcher and collector sitting directly upstream and downstream of a bank of `julia_worker` instances. On `frame_start`, it latches the Julia constant and scans every pixel coordinate in raster order. It hands each coordinate to an idle worker via the `JW_start` handshake and collects each finished `pixel` via the `JW_done`/`MC_busy` handshake. Each result is written to the frame buffer at the address tagged to that worker.

---
 rtl/julia_pkg.sv | 16 +
 rtl/julia_prio_enc.sv | 14 +
 rtl/julia_master_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_julia_master_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// Shared constants and state encoding for the Julia frame dispatcher.
package julia_pkg;

  localparam int H_RES_DEF  = 640;
  localparam int V_RES_DEF  = 480;
  localparam int PIXEL_BITS = 8;
  localparam int COORD_BITS = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } mc_state_t;

endpackage

// File: rtl/julia_prio_enc.sv
// Lowest-index-wins priority encoder: one-hot grant plus a valid flag.
module julia_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         valid_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt_o   = req_i & (~req_i + N'(1));
  assign valid_o = |req_i;

endmodule

// File: rtl/julia_master_ctrl.sv
// Julia frame dispatcher/collector: raster-scans coordinates out to a worker bank
// and writes returned pixels to the frame buffer. JULIA_MC_PERF_EN adds perf counters.
//
// state    | meaning
// IDLE     | waiting for frame_start
// DISPATCH | issuing coordinates to idle workers, collecting results
// DRAIN    | all pixels issued, collecting remaining results
// DONE     | last pixel written, frame_done high for one cycle
module julia_master_ctrl
  import julia_pkg::*;
#(
  parameter int NUM_WORKERS = 4,
  parameter int H_RES       = H_RES_DEF,
  parameter int V_RES       = V_RES_DEF,
  parameter int WIDTH       = 22,
  parameter int ADDR_BITS   = 19
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic [WIDTH-1:0]              c_real_in,
  input  logic [WIDTH-1:0]              c_imag_in,
  output logic                          busy,
  output logic                          frame_done,
  output logic [WIDTH-1:0]              c_real_out,
  output logic [WIDTH-1:0]              c_imag_out,
  input  logic [NUM_WORKERS-1:0]        JW_ready,
  output logic [NUM_WORKERS-1:0]        JW_start,
  output logic [COORD_BITS-1:0]         x,
  output logic [COORD_BITS-1:0]         y,
  input  logic [NUM_WORKERS-1:0]        JW_done,
  input  logic [8*NUM_WORKERS-1:0]      pixel,
  output logic [NUM_WORKERS-1:0]        MC_busy,
  input  logic                          fb_stall,
  output logic                          fb_we,
  output logic [ADDR_BITS-1:0]          fb_addr,
  output logic [PIXEL_BITS-1:0]         fb_data,
  output logic [31:0]                   perf_cycles,
  output logic [31:0]                   perf_stalls
);

  localparam logic [COORD_BITS-1:0] X_LAST = COORD_BITS'(H_RES - 1);
  localparam logic [COORD_BITS-1:0] Y_LAST = COORD_BITS'(V_RES - 1);

  mc_state_t                state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     frame_done_q, frame_done_d;
  logic [WIDTH-1:0]         c_real_q, c_real_d;
  logic [WIDTH-1:0]         c_imag_q, c_imag_d;
  logic [NUM_WORKERS-1:0]   jw_start_q, jw_start_d;
  logic [NUM_WORKERS-1:0]   mc_busy_q, mc_busy_d;
  logic [NUM_WORKERS-1:0]   issued_q, issued_d;
  logic [COORD_BITS-1:0]    x_q, x_d, y_q, y_d;
  logic [COORD_BITS-1:0]    xcnt_q, xcnt_d, ycnt_q, ycnt_d;
  logic [ADDR_BITS-1:0]     addr_q, addr_d;
  logic                     fb_we_q, fb_we_d;
  logic [ADDR_BITS-1:0]     fb_addr_q, fb_addr_d;
  logic [PIXEL_BITS-1:0]    fb_data_q, fb_data_d;
  logic [ADDR_BITS-1:0]     tag_q [NUM_WORKERS];
  logic [ADDR_BITS-1:0]     tag_d [NUM_WORKERS];

  logic [NUM_WORKERS-1:0]   disp_req, disp_gnt, coll_req, coll_gnt;
  logic                     disp_valid, coll_valid;
  logic                     coll_active, do_disp, do_coll;
  logic [ADDR_BITS-1:0]     coll_tag;
  logic [PIXEL_BITS-1:0]    coll_pix;

  // A worker whose ack is on MC_busy this cycle is excluded from dispatch.
  assign disp_req = JW_ready & ~issued_q & mc_busy_q;
  assign coll_req = JW_done & issued_q;

  julia_prio_enc #(.N(NUM_WORKERS)) u_disp_enc (
    .req_i   (disp_req),
    .gnt_o   (disp_gnt),
    .valid_o (disp_valid)
  );

  julia_prio_enc #(.N(NUM_WORKERS)) u_coll_enc (
    .req_i   (coll_req),
    .gnt_o   (coll_gnt),
    .valid_o (coll_valid)
  );

  assign coll_active = (state_q == DISPATCH) || (state_q == DRAIN);
  assign do_disp     = (state_q == DISPATCH) && disp_valid;
  assign do_coll     = coll_active && coll_valid && !fb_stall;

  always_comb begin
    coll_tag = '0;
    coll_pix = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      coll_tag = coll_tag | (tag_q[i] & {ADDR_BITS{coll_gnt[i]}});
      coll_pix = coll_pix | (pixel[8*i +: 8] & {PIXEL_BITS{coll_gnt[i]}});
    end
  end

  always_comb begin
    state_d      = state_q;
    c_real_d     = c_real_q;
    c_imag_d     = c_imag_q;
    jw_start_d   = '0;
    mc_busy_d    = '1;
    issued_d     = issued_q;
    x_d          = x_q;
    y_d          = y_q;
    xcnt_d       = xcnt_q;
    ycnt_d       = ycnt_q;
    addr_d       = addr_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    frame_done_d = 1'b0;
    tag_d        = tag_q;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d  = DISPATCH;
          c_real_d = c_real_in;
          c_imag_d = c_imag_in;
          xcnt_d   = '0;
          ycnt_d   = '0;
          addr_d   = '0;
        end
      end
      DISPATCH: begin
        if (do_disp) begin
          jw_start_d = disp_gnt;
          x_d        = xcnt_q;
          y_d        = ycnt_q;
          issued_d   = issued_q | disp_gnt;
          for (int i = 0; i < NUM_WORKERS; i++) begin
            if (disp_gnt[i]) tag_d[i] = addr_q;
          end
          addr_d = addr_q + 1'b1;
          if (xcnt_q == X_LAST) begin
            xcnt_d = '0;
            if (ycnt_q == Y_LAST) state_d = DRAIN;
            else                  ycnt_d  = ycnt_q + 1'b1;
          end else begin
            xcnt_d = xcnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (issued_q == '0) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Collect works on a different worker than dispatch, so the issued bits never collide.
    if (do_coll) begin
      mc_busy_d = ~coll_gnt;
      fb_we_d   = 1'b1;
      fb_addr_d = coll_tag;
      fb_data_d = coll_pix;
      issued_d  = issued_d & ~coll_gnt;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      c_real_q     <= '0;
      c_imag_q     <= '0;
      jw_start_q   <= '0;
      mc_busy_q    <= '1;
      issued_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      xcnt_q       <= '0;
      ycnt_q       <= '0;
      addr_q       <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      tag_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      c_real_q     <= c_real_d;
      c_imag_q     <= c_imag_d;
      jw_start_q   <= jw_start_d;
      mc_busy_q    <= mc_busy_d;
      issued_q     <= issued_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xcnt_q       <= xcnt_d;
      ycnt_q       <= ycnt_d;
      addr_q       <= addr_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      tag_q        <= tag_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign c_real_out = c_real_q;
  assign c_imag_out = c_imag_q;
  assign JW_start   = jw_start_q;
  assign MC_busy    = mc_busy_q;
  assign x          = x_q;
  assign y          = y_q;
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;

`ifdef JULIA_MC_PERF_EN
  logic [31:0] perf_cycles_q, perf_stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (state_q == IDLE && frame_start) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (busy_q) perf_cycles_q <= perf_cycles_q + 1'b1;
      if (coll_active && coll_valid && fb_stall) perf_stalls_q <= perf_stalls_q + 1'b1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_julia_master_ctrl.sv
// Directed bench for julia_master_ctrl on a 4x2 frame with a behavioural worker bank.
module tb_julia_master_ctrl;

  localparam int NW = 4;
  localparam int HR = 4;
  localparam int VR = 2;
  localparam int W  = 22;
  localparam int AB = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, frame_start, fb_stall;
  logic [W-1:0]     c_real_in, c_imag_in, c_real_out, c_imag_out;
  logic             busy, frame_done, fb_we;
  logic [NW-1:0]    JW_ready, JW_start, JW_done, MC_busy;
  logic [9:0]       x, y;
  logic [8*NW-1:0]  pixel;
  logic [AB-1:0]    fb_addr;
  logic [7:0]       fb_data;
  logic [31:0]      perf_cycles, perf_stalls;

  julia_master_ctrl #(
    .NUM_WORKERS(NW), .H_RES(HR), .V_RES(VR), .WIDTH(W), .ADDR_BITS(AB)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .c_real_in(c_real_in), .c_imag_in(c_imag_in),
    .busy(busy), .frame_done(frame_done),
    .c_real_out(c_real_out), .c_imag_out(c_imag_out),
    .JW_ready(JW_ready), .JW_start(JW_start), .x(x), .y(y),
    .JW_done(JW_done), .pixel(pixel), .MC_busy(MC_busy),
    .fb_stall(fb_stall), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
  );

  // Worker bank: pixel value is {y[3:0], x[3:0]} after lat[i] cycles.
  logic [NW-1:0] w_idle, w_done, en;
  int            w_cnt [NW];
  int            lat   [NW];
  logic [7:0]    w_px  [NW];
  logic          wrst;

  assign JW_ready = w_idle & en;
  assign JW_done  = w_done;

  always_comb begin
    pixel = '0;
    for (int i = 0; i < NW; i++) pixel[8*i +: 8] = w_px[i];
  end

  always @(negedge clk) begin
    for (int i = 0; i < NW; i++) begin
      if (wrst) begin
        w_idle[i] = 1'b1; w_done[i] = 1'b0; w_cnt[i] = 0; w_px[i] = 8'h00;
      end else if (JW_start[i] && w_idle[i]) begin
        w_idle[i] = 1'b0; w_cnt[i] = lat[i]; w_px[i] = {y[3:0], x[3:0]};
      end else if (w_cnt[i] != 0) begin
        w_cnt[i] = w_cnt[i] - 1;
        if (w_cnt[i] == 0) w_done[i] = 1'b1;
      end else if (w_done[i] && !MC_busy[i]) begin
        w_done[i] = 1'b0; w_idle[i] = 1'b1;
      end
    end
  end

  // Monitor: records writes, dispatches and frame_done pulses.
  int          cyc = 0, fd_cnt = 0, fd_cyc = 0, onehot_err = 0;
  logic [AB-1:0] wr_addr [$];
  logic [7:0]    wr_data [$];
  int            wr_cyc  [$];
  logic [9:0]    d_x [$];
  logic [9:0]    d_y [$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fb_we) begin
      wr_addr.push_back(fb_addr); wr_data.push_back(fb_data); wr_cyc.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt = fd_cnt + 1; fd_cyc = cyc;
    end
    if (JW_start != '0) begin
      if ($countones(JW_start) != 1) onehot_err = onehot_err + 1;
      d_x.push_back(x); d_y.push_back(y);
    end
  end

  int checks = 0, errors = 0;
  logic [7:0] exp_data [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [W-1:0] cr, input logic [W-1:0] ci);
    @(negedge clk);
    c_real_in = cr; c_imag_in = ci; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_frame(input int fd_base, input string tag);
    int n = 0;
    while (fd_cnt == fd_base && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_frame_done_seen"}, 64'(fd_cnt != fd_base), 64'(1));
    repeat (5) @(negedge clk);
  endtask

  task automatic check_frame(input int wb, input int db, input int fb, input string tag);
    int wcnt [8];
    int icnt [8];
    int a;
    for (int k = 0; k < 8; k++) begin wcnt[k] = 0; icnt[k] = 0; end
    chk({tag, "_num_writes"}, 64'(wr_addr.size() - wb), 64'(8));
    for (int j = wb; j < wr_addr.size(); j++) begin
      a = int'(wr_addr[j]);
      chk({tag, "_addr_range"}, 64'(a < 8), 64'(1));
      if (a < 8) begin
        wcnt[a]++;
        chk({tag, "_data"}, 64'(wr_data[j]), 64'(exp_data[a]));
      end
    end
    for (int j = db; j < d_x.size(); j++) begin
      a = int'(d_y[j]) * HR + int'(d_x[j]);
      if (a < 8) icnt[a]++;
    end
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_write_once"}, 64'(wcnt[k]), 64'(1));
      chk({tag, "_issue_once"}, 64'(icnt[k]), 64'(1));
    end
    chk({tag, "_frame_done_pulses"}, 64'(fd_cnt - fb), 64'(1));
    chk({tag, "_frame_done_timing"}, 64'(fd_cyc), 64'(wr_cyc[$] + 1));
    chk({tag, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  int wb, db, fb, oh0, n;
  logic seen;

  initial begin
    rst = 1'b1; wrst = 1'b1; frame_start = 1'b0; fb_stall = 1'b0;
    c_real_in = '0; c_imag_in = '0; en = '0;
    for (int i = 0; i < NW; i++) lat[i] = 5;
    repeat (3) @(negedge clk);
    rst = 1'b0; wrst = 1'b0;

    // Reset values
    chk("rst_busy",       64'(busy),        64'(0));
    chk("rst_frame_done", 64'(frame_done),  64'(0));
    chk("rst_jw_start",   64'(JW_start),    64'(0));
    chk("rst_fb_we",      64'(fb_we),       64'(0));
    chk("rst_fb_addr",    64'(fb_addr),     64'(0));
    chk("rst_fb_data",    64'(fb_data),     64'(0));
    chk("rst_xy",         64'({x, y}),      64'(0));
    chk("rst_c_out",      64'({c_real_out, c_imag_out}), 64'(0));
    chk("rst_mc_busy",    64'(MC_busy),     64'(4'hF));
    chk("rst_perf",       64'({perf_cycles, perf_stalls}), 64'(0));

    // Single worker, in-order frame
    en = 4'b0001; lat[0] = 5;
    wb = wr_addr.size(); db = d_x.size(); fb = fd_cnt; oh0 = onehot_err;
    start_frame(22'h000ABC, 22'h3FF123);
    chk("one_busy_after_start", 64'(busy), 64'(1));
    wait_frame(fb, "one");
    chk("one_c_real", 64'(c_real_out), 64'(22'h000ABC));
    chk("one_c_imag", 64'(c_imag_out), 64'(22'h3FF123));
    for (int j = 0; j < 8; j++)
      chk("one_order", 64'((wb + j < wr_addr.size()) ? int'(wr_addr[wb + j]) : -1), 64'(j));
    check_frame(wb, db, fb, "one");
`ifdef JULIA_MC_PERF_EN
    chk("one_perf_cycles_nz", 64'(perf_cycles != 0), 64'(1));
`else
    chk("one_perf_cycles_off", 64'(perf_cycles), 64'(0));
`endif

    // Four out-of-order workers, raster wrap, ignored restart
    en = 4'b1111; lat[0] = 3; lat[1] = 9; lat[2] = 1; lat[3] = 6;
    wb = wr_addr.size(); db = d_x.size(); fb = fd_cnt;
    start_frame(22'h012345, 22'h054321);
    @(negedge clk);
    c_real_in = 22'h3ABCDE; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("restart_c_real_kept", 64'(c_real_out), 64'(22'h012345));
    wait_frame(fb, "ooo");
    check_frame(wb, db, fb, "ooo");
    chk("ooo_c_real_after", 64'(c_real_out), 64'(22'h012345));
    chk("wrap_x_last",  64'(d_x[db + 3]), 64'(3));
    chk("wrap_y_last",  64'(d_y[db + 3]), 64'(0));
    chk("wrap_x_first", 64'(d_x[db + 4]), 64'(0));
    chk("wrap_y_next",  64'(d_y[db + 4]), 64'(1));

    // Back-pressure: two results held for ten stalled cycles
    en = 4'b0011; lat[0] = 3; lat[1] = 2;
    wb = wr_addr.size(); db = d_x.size(); fb = fd_cnt;
    fb_stall = 1'b1;
    start_frame(22'h000042, 22'h000024);
    seen = 1'b0; n = 0;
    while (!seen && n < 50) begin
      @(posedge clk);
      if (JW_done[1:0] == 2'b11) seen = 1'b1;
      n++;
    end
    chk("bp_both_done", 64'(seen), 64'(1));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_no_we",       64'(fb_we),   64'(0));
      chk("bp_mc_busy_hi",  64'(MC_busy), 64'(4'hF));
    end
    fb_stall = 1'b0;
    @(negedge clk);
    chk("bp_w0_we",      64'(fb_we),   64'(1));
    chk("bp_w0_addr",    64'(fb_addr), 64'(0));
    chk("bp_w0_data",    64'(fb_data), 64'(8'h00));
    chk("bp_w0_ack",     64'(MC_busy), 64'(4'b1110));
`ifdef JULIA_MC_PERF_EN
    chk("bp_perf_stalls", 64'(perf_stalls), 64'(10));
`else
    chk("bp_perf_stalls_off", 64'(perf_stalls), 64'(0));
`endif
    @(negedge clk);
    chk("bp_w1_we",      64'(fb_we),   64'(1));
    chk("bp_w1_addr",    64'(fb_addr), 64'(1));
    chk("bp_w1_data",    64'(fb_data), 64'(8'h01));
    chk("bp_w1_ack",     64'(MC_busy), 64'(4'b1101));
    wait_frame(fb, "bp");
    check_frame(wb, db, fb, "bp");

    // Reset with three workers outstanding
    en = 4'b0111; lat[0] = 20; lat[1] = 20; lat[2] = 20;
    db = d_x.size();
    start_frame(22'h000077, 22'h000088);
    repeat (4) @(negedge clk);
    chk("mid_outstanding", 64'(d_x.size() - db), 64'(3));
    fb = fd_cnt;
    rst = 1'b1; wrst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy",     64'(busy),       64'(0));
    chk("mid_jw_start", 64'(JW_start),   64'(0));
    chk("mid_fb_we",    64'(fb_we),      64'(0));
    chk("mid_fb_addr",  64'(fb_addr),    64'(0));
    chk("mid_fb_data",  64'(fb_data),    64'(0));
    chk("mid_mc_busy",  64'(MC_busy),    64'(4'hF));
    chk("mid_xy",       64'({x, y}),     64'(0));
    chk("mid_c_out",    64'({c_real_out, c_imag_out}), 64'(0));
    chk("mid_perf",     64'({perf_cycles, perf_stalls}), 64'(0));
    @(negedge clk);
    wrst = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_no_frame_done", 64'(fd_cnt - fb), 64'(0));

    lat[0] = 2; lat[1] = 2; lat[2] = 2;
    wb = wr_addr.size(); db = d_x.size(); fb = fd_cnt;
    start_frame(22'h000111, 22'h000222);
    wait_frame(fb, "restart");
    chk("restart_first_x", 64'(d_x[db]), 64'(0));
    chk("restart_first_y", 64'(d_y[db]), 64'(0));
    check_frame(wb, db, fb, "restart");
    chk("onehot_start", 64'(onehot_err - oh0), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
